pingpong_buf_ctrl: RTL and testbench
====================================

PINGPONG_BUF_CTRL -- requirements
Module: pingpong_buf_ctrl

Interface
REQ-001 Parameters SHALL be: DW, default 32, data width; BAW, default 10, per-bank address width; N_DELAY, default 1, dpram_wrapper read latency (1..4).
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 cfg_len  in  BAW+1  words per bank fill, legal range 1..2^BAW; stable while any bank is non-EMPTY.
REQ-005 flush  in  1  synchronous clear of all control state.
REQ-006 wr_valid  in  1, wr_data  in  DW, wr_ready  out  1  producer handshake.
REQ-007 rd_ready  in  1  consumer permits one read issue this cycle.
REQ-008 o_valid  out  1, o_data  out  DW, o_last  out  1  consumer stream, no backpressure.
REQ-009 ram_ena, ram_wea  out  1; ram_addra  out  BAW+1; ram_dia  out  DW  write port of the dpram_wrapper instance.
REQ-010 ram_enb  out  1; ram_addrb  out  BAW+1; ram_dob  in  DW  read port of the dpram_wrapper instance.
REQ-011 bank_full  out  2  bit i = bank i FULL or DRAINING; busy  out  1  any bank non-EMPTY or read in flight.

Function
REQ-012 The RAM SHALL be split into bank 0 and bank 1; the RAM address MSB is the bank index and the lower BAW bits are the word index.
REQ-013 Each bank SHALL hold one of four states: EMPTY, FILLING, FULL, DRAINING.
REQ-014 wr_ready SHALL be 1 iff bank[wbank] is EMPTY or FILLING and cfg_len != 0; the decision is combinational from registered state only.
REQ-015 On wr_valid&&wr_ready: ram_ena=ram_wea=1, ram_addra={wbank,wcnt}, ram_dia=wr_data in the same cycle; bank[wbank] -> FILLING; wcnt increments.
REQ-016 When the accepted write has wcnt==cfg_len-1: bank[wbank] -> FULL, wcnt -> 0, wbank toggles, all on the next edge.
REQ-017 A read SHALL be issued when bank[rbank] is FULL or DRAINING, rd_ready=1 and flush=0: ram_enb=1, ram_addrb={rbank,rcnt}; bank -> DRAINING; rcnt increments.
REQ-018 When the issued read has rcnt==cfg_len-1: bank[rbank] -> EMPTY, rcnt -> 0, rbank toggles on the next edge; the bank is writable the following cycle.
REQ-019 o_valid SHALL assert exactly N_DELAY cycles after each issue with o_data=ram_dob; o_last SHALL assert with the word issued at rcnt==cfg_len-1.
REQ-020 ram_ena/ram_wea/ram_enb SHALL be 0 in every cycle without an issue; address/data outputs are don't-care then.
REQ-021 Write into one bank and read from the other in the same cycle SHALL both proceed; a write and a read never target the same bank in the same cycle.
REQ-022 Bank release (REQ-018) and fill completion (REQ-016) on different banks in the same edge SHALL both take effect.
REQ-023 cfg_len==2^BAW SHALL use the full bank; word counters never wrap past cfg_len-1.
REQ-024 flush=1 SHALL block all issues that cycle and on the next edge set both banks EMPTY, wbank=rbank=0, wcnt=rcnt=0, and clear the o_valid/o_last pipeline (in-flight reads discarded).

Reset
REQ-025 While rstn=0 at a rising edge, state SHALL equal the post-flush state; o_valid=o_last=0, wr_ready=0 during reset, bank_full=0, busy=0, all ram enables 0.
REQ-026 Reset mid-fill or mid-drain SHALL discard data; the first write after reset goes to address 0.

Verification
REQ-027 cfg_len=4, write 0xA0..0xA3 back-to-back, rd_ready=0 -> addra 0..3, bank_full=01, wr_ready stays 1 (bank 1 EMPTY).
REQ-028 Continue 0xB0..0xB3 -> addra 0x400..0x403 (BAW=10), bank_full=11, wr_ready=0; extra wr_valid not accepted.
REQ-029 Then rd_ready=1 constantly -> addrb 0,1,2,3,0x400..0x403; o_data A0..A3,B0..B3 each one cycle after issue; o_last on A3 and B3; wr_ready returns 1 the cycle after addrb=3 issues.
REQ-030 Streaming: continuous writes and rd_ready=1, cfg_len=1 -> alternating banks, no lost or duplicated word over 64 words, scoreboard order preserved.
REQ-031 rd_ready toggled 1/0 during drain -> issues only on rd_ready=1 cycles; o_valid gaps match; data order intact.
REQ-032 flush (and separately rstn=0) asserted after 2 of 4 reads with one read in flight -> no o_valid next cycle, bank_full=00, busy=0, next write lands at addra 0.

Source files
------------

// File: rtl/pingpong_buf_ctrl_if.sv
// Producer, consumer and dual-port RAM signals of the ping-pong buffer controller.
// The slave modport is the controller; the master modport is the surrounding logic.
interface pingpong_buf_ctrl_if #(
    parameter int DW  = 32,
    parameter int BAW = 10
);
    logic           wr_valid;
    logic [DW-1:0]  wr_data;
    logic           wr_ready;
    logic           rd_ready;
    logic           o_valid;
    logic [DW-1:0]  o_data;
    logic           o_last;
    logic           ram_ena;
    logic           ram_wea;
    logic [BAW:0]   ram_addra;
    logic [DW-1:0]  ram_dia;
    logic           ram_enb;
    logic [BAW:0]   ram_addrb;
    logic [DW-1:0]  ram_dob;
    logic [1:0]     bank_full;
    logic           busy;

    modport slave (
        input  wr_valid, wr_data, rd_ready, ram_dob,
        output wr_ready, o_valid, o_data, o_last,
               ram_ena, ram_wea, ram_addra, ram_dia,
               ram_enb, ram_addrb, bank_full, busy
    );

    modport master (
        output wr_valid, wr_data, rd_ready, ram_dob,
        input  wr_ready, o_valid, o_data, o_last,
               ram_ena, ram_wea, ram_addra, ram_dia,
               ram_enb, ram_addrb, bank_full, busy
    );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank ping-pong controller: fills one RAM bank while draining the other.
// Write/read issue in the issuing cycle; o_valid N_DELAY cycles after a read issue; no output backpressure.
module pingpong_buf_ctrl #(
    parameter int DW      = 32,
    parameter int BAW     = 10,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [BAW:0]  cfg_len,
    input  logic          flush,
    pingpong_buf_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_st_e;

    bank_st_e             bank_q [2];
    bank_st_e             bank_d [2];
    logic                 wbank_q, wbank_d;
    logic                 rbank_q, rbank_d;
    logic [BAW-1:0]       wcnt_q, wcnt_d;
    logic [BAW-1:0]       rcnt_q, rcnt_d;
    logic [N_DELAY-1:0]   vld_q;
    logic [N_DELAY-1:0]   last_q;

    logic [BAW:0]         len_m1;
    logic                 wr_open, rd_open;
    logic                 wr_fire, rd_fire;
    logic                 wr_last, rd_last;

    assign len_m1  = cfg_len - (BAW+1)'(1);
    assign wr_last = ({1'b0, wcnt_q} == len_m1);
    assign rd_last = ({1'b0, rcnt_q} == len_m1);

    assign wr_open = (bank_q[wbank_q] == B_EMPTY) || (bank_q[wbank_q] == B_FILLING);
    assign rd_open = (bank_q[rbank_q] == B_FULL)  || (bank_q[rbank_q] == B_DRAINING);

    // The write bank is never readable and vice versa, so both ports can fire together.
    assign bus.wr_ready = rstn && wr_open && (cfg_len != '0);
    assign wr_fire      = bus.wr_valid && bus.wr_ready && !flush;
    assign rd_fire      = rstn && rd_open && bus.rd_ready && !flush;

    assign bus.ram_ena   = wr_fire;
    assign bus.ram_wea   = wr_fire;
    assign bus.ram_addra = {wbank_q, wcnt_q};
    assign bus.ram_dia   = bus.wr_data;
    assign bus.ram_enb   = rd_fire;
    assign bus.ram_addrb = {rbank_q, rcnt_q};

    assign bus.o_valid = rstn && vld_q[N_DELAY-1];
    assign bus.o_last  = rstn && last_q[N_DELAY-1];
    assign bus.o_data  = bus.ram_dob;

    assign bus.bank_full[0] = rstn && ((bank_q[0] == B_FULL) || (bank_q[0] == B_DRAINING));
    assign bus.bank_full[1] = rstn && ((bank_q[1] == B_FULL) || (bank_q[1] == B_DRAINING));
    assign bus.busy         = rstn && ((bank_q[0] != B_EMPTY) || (bank_q[1] != B_EMPTY) || (|vld_q));

    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wbank_d   = wbank_q;
        rbank_d   = rbank_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;

        if (wr_fire) begin
            if (wr_last) begin
                bank_d[wbank_q] = B_FULL;
                wcnt_d          = '0;
                wbank_d         = ~wbank_q;
            end else begin
                bank_d[wbank_q] = B_FILLING;
                wcnt_d          = wcnt_q + BAW'(1);
            end
        end

        if (rd_fire) begin
            if (rd_last) begin
                bank_d[rbank_q] = B_EMPTY;
                rcnt_d          = '0;
                rbank_d         = ~rbank_q;
            end else begin
                bank_d[rbank_q] = B_DRAINING;
                rcnt_d          = rcnt_q + BAW'(1);
            end
        end
    end

    // Flush and reset share one clear path; in-flight reads are dropped from the pipe.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            bank_q[0] <= B_EMPTY;
            bank_q[1] <= B_EMPTY;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            vld_q     <= '0;
            last_q    <= '0;
        end else begin
            bank_q    <= bank_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            vld_q     <= N_DELAY'({vld_q, rd_fire});
            last_q    <= N_DELAY'({last_q, rd_fire && rd_last});
        end
    end

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Bench for pingpong_buf_ctrl: directed vector table, flush/reset sequences, and
// random traffic checked against a fill-count reference model with a word queue.
module tb_pingpong_buf_ctrl;
    localparam int DW  = 32;
    localparam int BAW = 10;
    localparam int ND  = 1;
    localparam int NB  = 1 << BAW;

    logic         clk = 1'b0;
    logic         rstn;
    logic         flush;
    logic [BAW:0] cfg_len;

    always #5 clk = ~clk;

    pingpong_buf_ctrl_if #(.DW(DW), .BAW(BAW)) bi ();

    pingpong_buf_ctrl #(.DW(DW), .BAW(BAW), .N_DELAY(ND)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .cfg_len (cfg_len),
        .flush   (flush),
        .bus     (bi)
    );

    // Dual-port RAM with ND-cycle read latency.
    logic [DW-1:0] mem   [2*NB];
    logic [DW-1:0] rpipe [ND];
    always @(posedge clk) begin
        if (bi.ram_ena && bi.ram_wea) mem[bi.ram_addra] <= bi.ram_dia;
        rpipe[0] <= mem[bi.ram_addrb];
        for (int i = 1; i < ND; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bi.ram_dob = rpipe[ND-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: completed fills (mW) vs fully-read fills (mR); fill k lives in bank k%2.
    int              mW, mR, mwc, mrc, mlen;
    int unsigned     mq[$];
    bit              ev [ND];
    bit              el [ND];
    logic [DW-1:0]   ed [ND];

    task automatic model_clear();
        mW = 0; mR = 0; mwc = 0; mrc = 0;
        mq.delete();
        for (int i = 0; i < ND; i++) begin
            ev[i] = 1'b0; el[i] = 1'b0; ed[i] = '0;
        end
    endtask

    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
        bit xw, xwf, xrf, anyv;
        logic [1:0] xbf;
        @(negedge clk);
        bi.wr_valid = wv; bi.wr_data = wd; bi.rd_ready = rr; flush = fl;
        #1;
        xw  = ((mW - mR) < 2) && (mlen != 0);
        xwf = wv && xw && !fl;
        xrf = rr && (mW > mR) && !fl;
        xbf = 2'b00;
        for (int k = mR; k < mW; k++) xbf[k % 2] = 1'b1;
        anyv = 1'b0;
        for (int i = 0; i < ND; i++) anyv |= ev[i];
        chk("wr_ready", bi.wr_ready, xw);
        chk("ram_ena", bi.ram_ena, xwf);
        if (xwf) begin
            chk("ram_wea", bi.ram_wea, 1);
            chk("ram_addra", bi.ram_addra, (mW % 2) * NB + mwc);
            chk("ram_dia", bi.ram_dia, wd);
        end
        chk("ram_enb", bi.ram_enb, xrf);
        if (xrf) chk("ram_addrb", bi.ram_addrb, (mR % 2) * NB + mrc);
        chk("bank_full", bi.bank_full, xbf);
        chk("busy", bi.busy, (mW > mR) || (mwc > 0) || anyv);
        chk("o_valid", bi.o_valid, ev[ND-1]);
        if (ev[ND-1]) begin
            chk("o_data", bi.o_data, ed[ND-1]);
            chk("o_last", bi.o_last, el[ND-1]);
        end
        if (fl) begin
            model_clear();
        end else begin
            for (int i = ND-1; i > 0; i--) begin
                ev[i] = ev[i-1]; el[i] = el[i-1]; ed[i] = ed[i-1];
            end
            ev[0] = xrf;
            el[0] = xrf && (mrc == mlen - 1);
            ed[0] = (xrf && mq.size() > 0) ? mq.pop_front() : '0;
            if (xwf) begin
                mq.push_back(wd);
                mwc++;
                if (mwc == mlen) begin mwc = 0; mW++; end
            end
            if (xrf) begin
                mrc++;
                if (mrc == mlen) begin mrc = 0; mR++; end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; flush = 1'b0; bi.wr_valid = 1'b1; bi.rd_ready = 1'b1;
        #1;
        chk("rst_wr_ready", bi.wr_ready, 0);
        chk("rst_ram_ena", bi.ram_ena, 0);
        chk("rst_ram_enb", bi.ram_enb, 0);
        chk("rst_bank_full", bi.bank_full, 0);
        chk("rst_busy", bi.busy, 0);
        chk("rst_o_valid", bi.o_valid, 0);
        chk("rst_o_last", bi.o_last, 0);
        @(negedge clk);
        rstn = 1'b1; bi.wr_valid = 1'b0; bi.rd_ready = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit            wv;
        logic [DW-1:0] wd;
        bit            rr;
        bit            x_wrdy;
        bit            x_ena;
        logic [BAW:0]  x_addra;
        bit            x_enb;
        logic [BAW:0]  x_addrb;
        logic [1:0]    x_bf;
        bit            x_ov;
        logic [DW-1:0] x_od;
        bit            x_ol;
    } vec_t;

    function automatic vec_t mk(bit wv, logic [DW-1:0] wd, bit rr, bit xw, bit xe, logic [BAW:0] xa,
                                bit xb, logic [BAW:0] xab, logic [1:0] xbf, bit xov,
                                logic [DW-1:0] xod, bit xol);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.x_wrdy = xw; v.x_ena = xe; v.x_addra = xa;
        v.x_enb = xb; v.x_addrb = xab; v.x_bf = xbf; v.x_ov = xov; v.x_od = xod; v.x_ol = xol;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; cfg_len = 4;
        bi.wr_valid = 1'b0; bi.wr_data = '0; bi.rd_ready = 1'b0;
        mlen = 4;
        model_clear();

        // Two full banks of 4 words, one refused write, then a continuous drain.
        for (int i = 0; i < 4; i++)
            tbl[i] = mk(1, 32'hA0 + i, 0, 1, 1, 11'(i), 0, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            tbl[4+i] = mk(1, 32'hB0 + i, 0, 1, 1, 11'(NB + i), 0, 0, 2'b01, 0, 0, 0);
        tbl[8] = mk(1, 32'hFF, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            tbl[9+i] = mk(0, 0, 1, (i >= 4), 0, 0, 1,
                          (i < 4) ? 11'(i) : 11'(NB + i - 4),
                          (i < 4) ? 2'b11 : 2'b10,
                          (i >= 1),
                          (i == 0) ? 32'h0 : (i <= 4) ? 32'hA0 + i - 1 : 32'hB0 + i - 5,
                          (i == 4));
        tbl[17] = mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 1, 32'hB3, 1);

        do_reset();

        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            bi.wr_valid = tbl[r].wv; bi.wr_data = tbl[r].wd; bi.rd_ready = tbl[r].rr; flush = 1'b0;
            #1;
            chk($sformatf("t%0d_wr_ready", r), bi.wr_ready, tbl[r].x_wrdy);
            chk($sformatf("t%0d_ram_ena", r), bi.ram_ena, tbl[r].x_ena);
            if (tbl[r].x_ena) begin
                chk($sformatf("t%0d_ram_addra", r), bi.ram_addra, tbl[r].x_addra);
                chk($sformatf("t%0d_ram_dia", r), bi.ram_dia, tbl[r].wd);
            end
            chk($sformatf("t%0d_ram_enb", r), bi.ram_enb, tbl[r].x_enb);
            if (tbl[r].x_enb) chk($sformatf("t%0d_ram_addrb", r), bi.ram_addrb, tbl[r].x_addrb);
            chk($sformatf("t%0d_bank_full", r), bi.bank_full, tbl[r].x_bf);
            chk($sformatf("t%0d_o_valid", r), bi.o_valid, tbl[r].x_ov);
            if (tbl[r].x_ov) begin
                chk($sformatf("t%0d_o_data", r), bi.o_data, tbl[r].x_od);
                chk($sformatf("t%0d_o_last", r), bi.o_last, tbl[r].x_ol);
            end
        end
        model_clear();

        // Flush with one read in flight after two of four reads.
        for (int i = 0; i < 4; i++) cycle(1, 32'hC0 + i, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        cycle(1, 32'hD0, 0, 0);

        // Same scenario ended by reset instead of flush.
        for (int i = 0; i < 4; i++) cycle(1, 32'hE0 + i, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        do_reset();
        cycle(1, 32'hE5, 0, 0);

        // Single-word banks streaming one word per cycle.
        cycle(0, 0, 0, 1);
        cfg_len = 1; mlen = 1;
        for (int i = 0; i < 66; i++) cycle(1, $urandom, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Drain with rd_ready toggling.
        cycle(0, 0, 0, 1);
        cfg_len = 4; mlen = 4;
        for (int i = 0; i < 8; i++) cycle(1, $urandom, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, (i % 2 == 0), 0);

        // Random traffic across several fill lengths.
        for (int l = 1; l <= 5; l++) begin
            cycle(0, 0, 0, 1);
            cfg_len = (BAW+1)'(l); mlen = l;
            for (int i = 0; i < 300; i++)
                cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 0);
        end

        // Full-size banks.
        cycle(0, 0, 0, 1);
        cfg_len = (BAW+1)'(NB); mlen = NB;
        for (int i = 0; i < 2 * NB + 4; i++) cycle(1, $urandom, 0, 0);
        for (int i = 0; i < 2 * NB + 4; i++) cycle($urandom_range(0, 1) == 1, $urandom, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
